// File: rtl/mem_io_bridge.sv
// CPU memory-port decoder: routes byte accesses to RAM or to memory-mapped I/O
// (UART TX/RX FIFOs, cycle counter snapshot, program-stop flag) with 1-cycle read latency.
module mem_io_bridge #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    input  logic [7:0]  ram_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog_done,
    output logic        tx_overflow
);
    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam logic [TXW:0] TX_FULL = (TXW+1)'(TX_DEPTH);
    localparam logic [TXW:0] TX_HIGH = (TXW+1)'(TX_DEPTH - 1);
    localparam logic [RXW:0] RX_FULL = (RXW+1)'(RX_DEPTH);

    logic       io;
    logic [2:0] off;
    logic       unused_addr_bits;

    assign io               = (cpu_a[17:16] == 2'b11);
    assign off              = cpu_a[2:0];
    assign unused_addr_bits = ^{cpu_a[31:18], cpu_a[15:3]};

    assign ram_a    = cpu_a[16:0];
    assign ram_dout = cpu_dout;
    assign ram_we   = cpu_wr & ~io & rdy_in;

    // CPU-side I/O strobes; all gated by rdy_in
    logic io_rd, rx_rd, snap_rd, io_wr, stop_wr, tx_push_req;
    logic [7:0] tx_push_byte;

    assign io_rd        = rdy_in & io & ~cpu_wr;
    assign rx_rd        = io_rd & (off == 3'd0);
    assign snap_rd      = io_rd & (off == 3'd4);
    assign io_wr        = rdy_in & io & cpu_wr & ~prog_done;
    assign stop_wr      = io_wr & (off == 3'd4);
    assign tx_push_req  = stop_wr | (io_wr & (off == 3'd0) & (cpu_dout != 8'h00));
    assign tx_push_byte = stop_wr ? 8'h00 : cpu_dout;

    // TX FIFO
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TXW-1:0] tx_wp, tx_rp;
    logic [TXW:0]   tx_cnt;
    logic           tx_pop, tx_push;

    assign tx_valid       = (tx_cnt != '0);
    assign tx_data        = tx_mem[tx_rp];
    assign tx_pop         = tx_valid & tx_ready;
    assign tx_push        = tx_push_req & ((tx_cnt != TX_FULL) | tx_pop);
    assign io_buffer_full = (tx_cnt >= TX_HIGH);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_wp       <= '0;
            tx_rp       <= '0;
            tx_cnt      <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + (TXW+1)'(tx_push) - (TXW+1)'(tx_pop);
            if (tx_push_req & ~tx_push) tx_overflow <= 1'b1;
        end
    end

    // At full with a pop, wp == rp: the head is read out before the slot is rewritten
    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wp] <= tx_push_byte;
    end

    // RX FIFO
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RXW-1:0] rx_wp, rx_rp;
    logic [RXW:0]   rx_cnt;
    logic           rx_push, rx_pop;

    assign rx_ready = ~rst_in & (rx_cnt != RX_FULL);
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rx_rd & (rx_cnt != '0);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + (RXW+1)'(rx_push) - (RXW+1)'(rx_pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    // CPU-side registers
    logic [4:0]  sel_q;
    logic [7:0]  rx_q;
    logic [31:0] snap, cycle_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sel_q     <= '0;
            rx_q      <= '0;
            snap      <= '0;
            cycle_cnt <= '0;
            prog_done <= 1'b0;
        end else if (rdy_in) begin
            sel_q     <= {io, off, cpu_wr};
            cycle_cnt <= cycle_cnt + 32'd1;
            if (rx_rd)   rx_q <= rx_pop ? rx_mem[rx_rp] : 8'h00;
            if (snap_rd) snap <= cycle_cnt;
            if (stop_wr) prog_done <= 1'b1;
        end
    end

    logic       sel_io, sel_wr;
    logic [2:0] sel_off;

    assign {sel_io, sel_off, sel_wr} = sel_q;

    always_comb begin
        cpu_din = 8'h00;
        if (!sel_wr) begin
            if (!sel_io) begin
                cpu_din = ram_din;
            end else begin
                case (sel_off)
                    3'd0:    cpu_din = rx_q;
                    3'd4:    cpu_din = snap[7:0];
                    3'd5:    cpu_din = snap[15:8];
                    3'd6:    cpu_din = snap[23:16];
                    3'd7:    cpu_din = snap[31:24];
                    default: cpu_din = 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: random traffic against queue/array models
// of RAM, the UART FIFOs and the cycle counter.
module tb_mem_io_bridge;
    localparam int TXD = 8;
    localparam int RXD = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [31:0] cpu_a = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  ram_din = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        prog_done;
    logic        tx_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    mem_io_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .io_buffer_full(io_buffer_full),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_we(ram_we), .ram_din(ram_din),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .prog_done(prog_done), .tx_overflow(tx_overflow)
    );

    // Synchronous RAM attached to the bridge
    logic [7:0] ram_mem [131072];
    int we_pulses = 0;
    always @(posedge clk_in) begin
        if (ram_we) begin
            ram_mem[ram_a] <= ram_dout;
            we_pulses <= we_pulses + 1;
        end
        ram_din <= ram_mem[ram_a];
    end

    // Reference models
    logic [7:0] ram_model [int];
    logic [7:0] rxm [$];
    logic [7:0] txm [$];
    logic [7:0] tx_got [$];

    task automatic bus_op(input logic [31:0] a, input logic wr, input logic [7:0] d,
                          output logic [7:0] q);
        @(posedge clk_in); #1;
        cpu_a = a; cpu_wr = wr; cpu_dout = d;
        @(posedge clk_in); #1;
        cpu_a = '0; cpu_wr = 1'b0; cpu_dout = '0;
        q = cpu_din;
    endtask

    task automatic do_reset();
        @(negedge clk_in); #2;
        rst_in = 1'b1; cpu_a = '0; cpu_wr = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; rdy_in = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        rxm.delete(); txm.delete();
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(posedge clk_in); #1;
        rx_data = b; rx_valid = 1'b1;
        if (rxm.size() < RXD) rxm.push_back(b);
        @(posedge clk_in); #1;
        rx_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        tx_got.delete();
        @(posedge clk_in); #1;
        tx_ready = 1'b1;
        repeat (budget) begin
            @(negedge clk_in);
            if (tx_valid) tx_got.push_back(tx_data);
        end
        @(posedge clk_in); #1;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_in); #2;
        rst_in = 1'b1;
        #1;
        checks += 6;
        if (cpu_din !== 8'h00) begin errors++; $display("FAIL reset_cpu_din: got %h expected 00", cpu_din); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_iobf: got %b expected 0", io_buffer_full); end
        if (prog_done !== 1'b0) begin errors++; $display("FAIL reset_prog_done: got %b expected 0", prog_done); end
        if (tx_overflow !== 1'b0) begin errors++; $display("FAIL reset_tx_overflow: got %b expected 0", tx_overflow); end
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); end
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL release_rx_ready: got %b expected 1", rx_ready); end
    endtask

    task automatic test_ram();
        logic [7:0]  q, b;
        logic [31:0] addrs [$];
        int w0;
        w0 = we_pulses;
        bus_op(32'h0001_0 >> 4 << 4, 1'b1, 8'hA5, q);
        ram_model[32'h10] = 8'hA5;
        checks += 2;
        if (we_pulses !== w0 + 1) begin errors++; $display("FAIL ram_we_pulse: got %0d expected %0d", we_pulses - w0, 1); end
        if (q !== 8'h00) begin errors++; $display("FAIL ram_write_din: got %h expected 00", q); end
        bus_op(32'h0000_0010, 1'b0, 8'h00, q);
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL ram_roundtrip: got %h expected a5", q); end

        addrs = '{32'h0000_0020, 32'h0001_FFFF, 32'h0002_0030};
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  hi;
            logic [15:0] lo;
            hi = 2'($urandom_range(0, 2));
            lo = 16'($urandom);
            addrs.push_back({14'h0, hi, lo});
        end
        foreach (addrs[i]) begin
            b = (addrs[i] == 32'h20) ? 8'h5A : 8'($urandom);
            bus_op(addrs[i], 1'b1, b, q);
            ram_model[int'(addrs[i] % 32'h2_0000)] = b;
        end
        foreach (addrs[i]) begin
            bus_op(addrs[i], 1'b0, 8'h00, q);
            checks++;
            if (q !== ram_model[int'(addrs[i] % 32'h2_0000)])
                begin errors++; $display("FAIL ram_read[%h]: got %h expected %h", addrs[i], q, ram_model[int'(addrs[i] % 32'h2_0000)]); end
        end
    endtask

    task automatic test_tx();
        logic [7:0] q, b;
        logic [7:0] stim [$];
        int w0;
        do_reset();
        stim = '{8'h41, 8'h00, 8'h42};
        for (int i = 0; i < 4; i++) begin
            b = (i == 1) ? 8'h00 : 8'($urandom);
            stim.push_back(b);
        end
        w0 = we_pulses;
        foreach (stim[i]) begin
            bus_op(32'h0003_0000, 1'b1, stim[i], q);
            if (stim[i] != 8'h00) txm.push_back(stim[i]);
            if (i == 0) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== 8'h41)
                    begin errors++; $display("FAIL tx_first_visible: got valid=%b data=%h expected valid=1 data=41", tx_valid, tx_data); end
            end
        end
        checks++;
        if (we_pulses !== w0) begin errors++; $display("FAIL io_write_ram_we: got %0d pulses expected 0", we_pulses - w0); end
        drain(txm.size() + 4);
        checks++;
        if (tx_got.size() !== txm.size()) begin errors++; $display("FAIL tx_count: got %0d expected %0d", tx_got.size(), txm.size()); end
        for (int i = 0; i < txm.size() && i < tx_got.size(); i++) begin
            checks++;
            if (tx_got[i] !== txm[i]) begin errors++; $display("FAIL tx_byte[%0d]: got %h expected %h", i, tx_got[i], txm[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] q, b;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            b = 8'($urandom_range(1, 255));
            bus_op(32'h0003_0000, 1'b1, b, q);
            txm.push_back(b);
            if (i == 6) begin
                checks++;
                if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL iobf_at_6: got %b expected 0", io_buffer_full); end
            end
            if (i == 7) begin
                checks++;
                if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL iobf_at_7: got %b expected 1", io_buffer_full); end
            end
        end
        // push and pop in the same cycle while full
        b = 8'($urandom_range(1, 255));
        @(posedge clk_in); #1;
        cpu_a = 32'h0003_0000; cpu_wr = 1'b1; cpu_dout = b; tx_ready = 1'b1;
        @(posedge clk_in); #1;
        cpu_a = '0; cpu_wr = 1'b0; tx_ready = 1'b0;
        void'(txm.pop_front());
        txm.push_back(b);
        checks += 2;
        if (tx_overflow !== 1'b0) begin errors++; $display("FAIL full_push_pop_ovf: got %b expected 0", tx_overflow); end
        if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL full_push_pop_iobf: got %b expected 1", io_buffer_full); end
        bus_op(32'h0003_0000, 1'b1, 8'hEE, q);
        checks++;
        if (tx_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", tx_overflow); end
        drain(12);
        checks += 2;
        if (tx_got.size() !== TXD) begin errors++; $display("FAIL drain_count: got %0d expected %0d", tx_got.size(), TXD); end
        if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0)
            begin errors++; $display("FAIL drain_empty: got valid=%b iobf=%b expected 0 0", tx_valid, io_buffer_full); end
        for (int i = 0; i < txm.size() && i < tx_got.size(); i++) begin
            checks++;
            if (tx_got[i] !== txm[i]) begin errors++; $display("FAIL drain_byte[%0d]: got %h expected %h", i, tx_got[i], txm[i]); end
        end
    endtask

    task automatic test_rx();
        logic [7:0] q, e, b;
        do_reset();
        rx_push(8'h31);
        rx_push(8'h32);
        for (int i = 0; i < 3; i++) begin
            bus_op(32'h0003_0000, 1'b0, 8'h00, q);
            e = (rxm.size() != 0) ? rxm.pop_front() : 8'h00;
            checks++;
            if (q !== e) begin errors++; $display("FAIL rx_read[%0d]: got %h expected %h", i, q, e); end
        end
        for (int i = 0; i < RXD + 1; i++) begin
            rx_push(8'($urandom));
            if (i == RXD - 1) begin
                checks++;
                if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b expected 0", rx_ready); end
            end
        end
        for (int i = 0; i < RXD + 1; i++) begin
            bus_op(32'h0003_0000, 1'b0, 8'h00, q);
            e = (rxm.size() != 0) ? rxm.pop_front() : 8'h00;
            checks++;
            if (q !== e) begin errors++; $display("FAIL rx_fill_read[%0d]: got %h expected %h", i, q, e); end
        end
        // push and pop together on empty: the pop sees empty, the push lands
        b = 8'($urandom_range(1, 255));
        @(posedge clk_in); #1;
        cpu_a = 32'h0003_0000; cpu_wr = 1'b0; rx_data = b; rx_valid = 1'b1;
        @(posedge clk_in); #1;
        cpu_a = '0; rx_valid = 1'b0;
        checks++;
        if (cpu_din !== 8'h00) begin errors++; $display("FAIL rx_empty_pushpop: got %h expected 00", cpu_din); end
        bus_op(32'h0003_0000, 1'b0, 8'h00, q);
        checks++;
        if (q !== b) begin errors++; $display("FAIL rx_after_pushpop: got %h expected %h", q, b); end
    endtask

    task automatic test_cycle();
        logic [7:0]  q;
        logic [31:0] exp_snap;
        int n, k, w0;
        do_reset();
        n = 0;
        repeat (100) begin @(posedge clk_in); n++; end
        #1;
        rdy_in = 1'b0; cpu_a = 32'h0000_0020; cpu_wr = 1'b1; cpu_dout = 8'h77;
        w0 = we_pulses;
        #1;
        checks++;
        if (ram_we !== 1'b0) begin errors++; $display("FAIL rdy_low_ram_we: got %b expected 0", ram_we); end
        repeat (20) @(posedge clk_in);
        #1;
        rdy_in = 1'b1; cpu_wr = 1'b0; cpu_a = '0;
        k = $urandom_range(3, 12);
        repeat (k) begin @(posedge clk_in); n++; end
        #1;
        cpu_a = 32'h0003_0004;
        exp_snap = 32'(n);
        @(posedge clk_in); #1;
        cpu_a = '0;
        checks += 2;
        if (cpu_din !== exp_snap[7:0]) begin errors++; $display("FAIL snap_b0: got %h expected %h", cpu_din, exp_snap[7:0]); end
        if (we_pulses !== w0) begin errors++; $display("FAIL rdy_low_write: got %0d pulses expected 0", we_pulses - w0); end
        bus_op(32'h0003_0005, 1'b0, 8'h00, q);
        checks++;
        if (q !== exp_snap[15:8]) begin errors++; $display("FAIL snap_b1: got %h expected %h", q, exp_snap[15:8]); end
        bus_op(32'h0003_0006, 1'b0, 8'h00, q);
        checks++;
        if (q !== exp_snap[23:16]) begin errors++; $display("FAIL snap_b2: got %h expected %h", q, exp_snap[23:16]); end
        bus_op(32'h0003_0007, 1'b0, 8'h00, q);
        checks++;
        if (q !== exp_snap[31:24]) begin errors++; $display("FAIL snap_b3: got %h expected %h", q, exp_snap[31:24]); end
        // rdy low: sel_q and snap must hold even with a 0x30004 read on the bus
        rdy_in = 1'b0; cpu_a = 32'h0003_0004;
        repeat (5) @(posedge clk_in);
        #1;
        checks++;
        if (cpu_din !== exp_snap[31:24]) begin errors++; $display("FAIL rdy_low_hold: got %h expected %h", cpu_din, exp_snap[31:24]); end
        rdy_in = 1'b1; cpu_a = '0;
        bus_op(32'h0003_0001, 1'b0, 8'h00, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL io_other_offset: got %h expected 00", q); end
        bus_op(32'h0000_0020, 1'b0, 8'h00, q);
        checks++;
        if (q !== ram_model[32'h20]) begin errors++; $display("FAIL rdy_low_ram_kept: got %h expected %h", q, ram_model[32'h20]); end
    endtask

    task automatic test_stop();
        logic [7:0] q;
        do_reset();
        bus_op(32'h0003_0004, 1'b1, 8'($urandom), q);
        checks += 2;
        if (prog_done !== 1'b1) begin errors++; $display("FAIL stop_prog_done: got %b expected 1", prog_done); end
        if (tx_valid !== 1'b1 || tx_data !== 8'h00)
            begin errors++; $display("FAIL stop_tx_zero: got valid=%b data=%h expected 1 00", tx_valid, tx_data); end
        bus_op(32'h0003_0000, 1'b1, 8'h41, q);
        bus_op(32'h0003_0004, 1'b1, 8'h55, q);
        drain(6);
        checks += 2;
        if (tx_got.size() !== 1) begin errors++; $display("FAIL stop_tx_count: got %0d expected 1", tx_got.size()); end
        else if (tx_got[0] !== 8'h00) begin errors++; $display("FAIL stop_tx_byte: got %h expected 00", tx_got[0]); end
        if (prog_done !== 1'b1) begin errors++; $display("FAIL stop_sticky: got %b expected 1", prog_done); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q;
        do_reset();
        rx_push(8'h99);
        for (int i = 0; i < TXD; i++) bus_op(32'h0003_0000, 1'b1, 8'($urandom_range(1, 255)), q);
        bus_op(32'h0003_0004, 1'b1, 8'h00, q);
        checks++;
        if (prog_done !== 1'b1 || tx_overflow !== 1'b1)
            begin errors++; $display("FAIL pre_reset_flags: got done=%b ovf=%b expected 1 1", prog_done, tx_overflow); end
        bus_op(32'h0003_0005, 1'b0, 8'h00, q);
        @(posedge clk_in); #1;
        tx_ready = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in); #3;
        rst_in = 1'b1;
        #1;
        checks += 6;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_tx_valid: got %b expected 0", tx_valid); end
        if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL mid_reset_iobf: got %b expected 0", io_buffer_full); end
        if (prog_done !== 1'b0) begin errors++; $display("FAIL mid_reset_prog_done: got %b expected 0", prog_done); end
        if (tx_overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_ovf: got %b expected 0", tx_overflow); end
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_rx_ready: got %b expected 0", rx_ready); end
        if (cpu_din !== 8'h00) begin errors++; $display("FAIL mid_reset_cpu_din: got %h expected 00", cpu_din); end
        tx_ready = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        rxm.delete(); txm.delete();
        bus_op(32'h0003_0000, 1'b0, 8'h00, q);
        checks += 2;
        if (q !== 8'h00) begin errors++; $display("FAIL post_reset_rx_empty: got %h expected 00", q); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_tx_empty: got %b expected 0", tx_valid); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tx();
        test_overflow();
        test_rx();
        test_cycle();
        test_stop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
